// File: rtl/decoder_scan_pkg.sv
// Shared types and constants for the decoder scan sequencer.
// Contents: scan state enum, channel count, index width, frame counter width,
// and a lowest-set-bit helper used when a scan is started.
package decoder_scan_pkg;

    localparam int unsigned NUM_CH      = 8;
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        BLANK = 2'd2
    } scan_state_e;

    // Index of the lowest set bit of m; 0 when m is empty.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
        lowest_set = '0;
        for (int unsigned k = NUM_CH; k > 0; k--) begin
            if (m[k-1]) lowest_set = IDX_W'(k - 1);
        end
    endfunction

endpackage

// File: rtl/scan_next_sel.sv
// Combinational next-channel search for the decoder scan sequencer.
// Ports:
//   mask    - channels taking part in the current frame
//   cur_idx - channel currently selected
//   nxt_idx - next set bit of mask searching upward from cur_idx+1 modulo NUM_CH
//             (cur_idx when mask is empty)
//   wrap    - the search wrapped: nxt_idx <= cur_idx (includes a single-bit mask)
module scan_next_sel
    import decoder_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [IDX_W-1:0]  cur_idx,
    output logic [IDX_W-1:0]  nxt_idx,
    output logic              wrap
);

    logic             found;
    logic [IDX_W-1:0] idx;

    // Walk cur+1 .. cur+NUM_CH; the last step lands back on cur itself.
    always_comb begin
        nxt_idx = cur_idx;
        found   = 1'b0;
        idx     = cur_idx;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx = cur_idx + IDX_W'(k);
            if (!found && mask[idx]) begin
                found   = 1'b1;
                nxt_idx = idx;
            end
        end
        wrap = found && (nxt_idx <= cur_idx);
    end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer driving the select/enable pair of an active-low 3-to-8 decoder.
// Steps i through the channels enabled in mask, holding each for max(dwell,1)
// cycles with en low, separated by BLANK_CYC cycles with en high.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start, stop - scan requests (levels, sampled every cycle; stop wins)
//   mask        - channel enables, re-latched at every frame wrap
//   dwell       - active cycles per channel, sampled on each DRIVE entry
//   i           - decoder select
//   en          - decoder enable, active-low
//   busy        - high outside IDLE
//   wrap        - one-cycle pulse when the index wraps to a new frame
//   frame_cnt   - wrap counter, present only with DECODER_SCAN_FRAME_CNT_EN defined
module decoder_scan_ctrl
    import decoder_scan_pkg::*;
#(
    parameter int unsigned DWELL_W   = 8,
    parameter int unsigned BLANK_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [NUM_CH-1:0]  mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [IDX_W-1:0]   i,
    output logic               en,
    output logic               busy,
    output logic               wrap
`ifdef DECODER_SCAN_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

    localparam int unsigned BLANK_W = 4;
    // A stop always gets at least one blank cycle, so BLANK_CYC=0 also loads 0.
    localparam logic [BLANK_W-1:0] BLANK_LAST =
        (BLANK_CYC == 0) ? '0 : BLANK_W'(BLANK_CYC - 1);

    scan_state_e        state, state_d;
    logic [IDX_W-1:0]   i_d;
    logic               en_d, busy_d, wrap_d;
    logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_d;
    logic [BLANK_W-1:0] blank_cnt, blank_cnt_d;
    logic [NUM_CH-1:0]  frame_mask, frame_mask_d;
    logic               stop_lat, stop_lat_d;
    logic               end_frame, end_frame_d;

    logic [IDX_W-1:0]   next_idx;
    logic               next_wrap;

    // Counter reload: remaining DRIVE cycles after the first, dwell 0 acts as 1.
    function automatic logic [DWELL_W-1:0] dwell_last(input logic [DWELL_W-1:0] d);
        return (d == '0) ? '0 : d - DWELL_W'(1);
    endfunction

    scan_next_sel u_next_sel (
        .mask    (frame_mask),
        .cur_idx (i),
        .nxt_idx (next_idx),
        .wrap    (next_wrap)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            i          <= '0;
            en         <= 1'b1;
            busy       <= 1'b0;
            wrap       <= 1'b0;
            dwell_cnt  <= '0;
            blank_cnt  <= '0;
            frame_mask <= '0;
            stop_lat   <= 1'b0;
            end_frame  <= 1'b0;
        end else begin
            state      <= state_d;
            i          <= i_d;
            en         <= en_d;
            busy       <= busy_d;
            wrap       <= wrap_d;
            dwell_cnt  <= dwell_cnt_d;
            blank_cnt  <= blank_cnt_d;
            frame_mask <= frame_mask_d;
            stop_lat   <= stop_lat_d;
            end_frame  <= end_frame_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state;
        i_d          = i;
        en_d         = en;
        busy_d       = busy;
        wrap_d       = 1'b0;
        dwell_cnt_d  = dwell_cnt;
        blank_cnt_d  = blank_cnt;
        frame_mask_d = frame_mask;
        stop_lat_d   = stop_lat;
        end_frame_d  = end_frame;

        unique case (state)
            IDLE: begin
                en_d        = 1'b1;
                busy_d      = 1'b0;
                stop_lat_d  = 1'b0;
                end_frame_d = 1'b0;
                if (start && !stop && (mask != '0)) begin
                    frame_mask_d = mask;
                    i_d          = lowest_set(mask);
                    dwell_cnt_d  = dwell_last(dwell);
                    en_d         = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = DRIVE;
                end
            end

            DRIVE: begin
                if (stop) stop_lat_d = 1'b1;
                if (dwell_cnt != '0) begin
                    dwell_cnt_d = dwell_cnt - DWELL_W'(1);
                end else if (stop_lat || stop) begin
                    // Stopping: keep i, blank once, then IDLE.
                    en_d        = 1'b1;
                    blank_cnt_d = BLANK_LAST;
                    state_d     = BLANK;
                end else begin
                    i_d    = next_idx;
                    wrap_d = next_wrap;
                    if (next_wrap) frame_mask_d = mask;
                    if (BLANK_CYC == 0) begin
                        // No gap: straight into the next channel, or out if the frame emptied.
                        if (next_wrap && (mask == '0)) begin
                            en_d    = 1'b1;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            dwell_cnt_d = dwell_last(dwell);
                        end
                    end else begin
                        end_frame_d = next_wrap && (mask == '0);
                        en_d        = 1'b1;
                        blank_cnt_d = BLANK_LAST;
                        state_d     = BLANK;
                    end
                end
            end

            BLANK: begin
                if (stop) stop_lat_d = 1'b1;
                if (blank_cnt != '0) begin
                    blank_cnt_d = blank_cnt - BLANK_W'(1);
                end else if (stop_lat || stop || end_frame) begin
                    busy_d      = 1'b0;
                    stop_lat_d  = 1'b0;
                    end_frame_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    en_d        = 1'b0;
                    dwell_cnt_d = dwell_last(dwell);
                    state_d     = DRIVE;
                end
            end

            default: begin
                en_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

`ifdef DECODER_SCAN_FRAME_CNT_EN
    // Frame counter: advances with every wrap pulse, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (wrap_d) begin
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
        end
    end
`endif

endmodule
